line_cmd_sequencer: RTL and testbench

Command-side initiator for the line-drawing engine's command FIFO. The host fills a small line list, then pulses start. The block clears the frame buffer, waits for the engine to go idle, and pushes each stored segment into the engine FIFO under full-flag back-pressure. It then waits for drawing to finish and signals done. It sits between the control logic (buttons/switches or a future host interface) and draw_lines.

---
 rtl/line_cmd_sequencer_pkg.sv | 20 ++
 rtl/line_list_ram.sv | 62 ++++++
 rtl/line_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_line_cmd_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_cmd_sequencer_pkg.sv
// Shared definitions for the line command sequencer: state encoding, guard length and the
// coordinate-width defaults shared with draw_lines.
package line_cmd_sequencer_pkg;

  localparam int unsigned DefaultXCoordW = 11;
  localparam int unsigned DefaultYCoordW = 11;

  // Cycles spent after the clear pulse before i_waiting is trusted again.
  localparam int unsigned GuardCycles = 2;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGuard,
    StWaitClr,
    StLoad,
    StFlush
  } state_e;

endpackage

// File: rtl/line_list_ram.sv
// Line list storage: one entry per segment, coordinates clamped to the screen on write,
// registered read port.
module line_list_ram
  import line_cmd_sequencer_pkg::*;
#(
  parameter int unsigned XW       = DefaultXCoordW,
  parameter int unsigned YW       = DefaultYCoordW,
  parameter int unsigned ScreenW  = 640,
  parameter int unsigned ScreenH  = 480,
  parameter int unsigned NumLines = 16,
  parameter int unsigned IdxW     = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_addr_i,
  input  logic [XW-1:0]   wr_x0_i,
  input  logic [YW-1:0]   wr_y0_i,
  input  logic [XW-1:0]   wr_x1_i,
  input  logic [YW-1:0]   wr_y1_i,
  input  logic [IdxW-1:0] rd_addr_i,
  output logic [XW-1:0]   rd_x0_o,
  output logic [YW-1:0]   rd_y0_o,
  output logic [XW-1:0]   rd_x1_o,
  output logic [YW-1:0]   rd_y1_o
);

  localparam int unsigned EntryW = 2 * XW + 2 * YW;
  localparam logic [XW-1:0] MaxX = XW'(ScreenW - 1);
  localparam logic [YW-1:0] MaxY = YW'(ScreenH - 1);

  logic [EntryW-1:0] mem_q [NumLines];
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] rd_q;

  // Clamp every coordinate to the visible area before it is stored.
  always_comb begin
    wr_entry = {(wr_x0_i > MaxX) ? MaxX : wr_x0_i,
                (wr_y0_i > MaxY) ? MaxY : wr_y0_i,
                (wr_x1_i > MaxX) ? MaxX : wr_x1_i,
                (wr_y1_i > MaxY) ? MaxY : wr_y1_i};
  end

  // Storage array; contents are undefined after reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_entry;
    end
  end

  // Registered read; cleared on reset so the coordinate outputs start at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign {rd_x0_o, rd_y0_o, rd_x1_o, rd_y1_o} = rd_q;

endmodule

// File: rtl/line_cmd_sequencer.sv
// Command-side initiator for the line-drawing engine: clears the frame buffer, waits for the
// engine to idle, pushes the stored line list into the engine FIFO, then reports completion.
module line_cmd_sequencer
  import line_cmd_sequencer_pkg::*;
#(
  parameter int unsigned P_X_COORD_W = DefaultXCoordW,
  parameter int unsigned P_Y_COORD_W = DefaultYCoordW,
  parameter int unsigned P_SCREEN_W  = 640,
  parameter int unsigned P_SCREEN_H  = 480,
  parameter int unsigned P_NUM_LINES = 16,
  parameter int unsigned P_IDX_W     = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_wr_en,
  input  logic [P_IDX_W-1:0]     i_wr_addr,
  input  logic [P_X_COORD_W-1:0] i_wr_x0,
  input  logic [P_Y_COORD_W-1:0] i_wr_y0,
  input  logic [P_X_COORD_W-1:0] i_wr_x1,
  input  logic [P_Y_COORD_W-1:0] i_wr_y1,
  input  logic [P_IDX_W:0]       i_line_count,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_waiting,
  input  logic                   i_fifo_full,
  output logic                   o_clear_buffer,
  output logic                   o_load_fifo,
  output logic [P_X_COORD_W-1:0] o_x0,
  output logic [P_Y_COORD_W-1:0] o_y0,
  output logic [P_X_COORD_W-1:0] o_x1,
  output logic [P_Y_COORD_W-1:0] o_y1,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned CntW   = P_IDX_W + 1;
  localparam int unsigned GuardW = $clog2(GuardCycles + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   index_q, index_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic [CntW-1:0]   count_sat;

  assign o_busy    = (state_q != StIdle);
  assign count_sat = (i_line_count > CntW'(P_NUM_LINES)) ? CntW'(P_NUM_LINES) : i_line_count;

  // Read address follows the next index so the registered read lines up with each push.
  line_list_ram #(
    .XW       (P_X_COORD_W),
    .YW       (P_Y_COORD_W),
    .ScreenW  (P_SCREEN_W),
    .ScreenH  (P_SCREEN_H),
    .NumLines (P_NUM_LINES),
    .IdxW     (P_IDX_W)
  ) u_list (
    .clk_i     (i_clk),
    .rst_ni    (i_reset_n),
    .wr_en_i   (i_wr_en && !o_busy),
    .wr_addr_i (i_wr_addr),
    .wr_x0_i   (i_wr_x0),
    .wr_y0_i   (i_wr_y0),
    .wr_x1_i   (i_wr_x1),
    .wr_y1_i   (i_wr_y1),
    .rd_addr_i (index_d[P_IDX_W-1:0]),
    .rd_x0_o   (o_x0),
    .rd_y0_o   (o_y0),
    .rd_x1_o   (o_x1),
    .rd_y1_o   (o_y1)
  );

  // Next-state, index/count updates and the single-cycle strobes.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    index_d        = index_q;
    guard_d        = '0;
    o_clear_buffer = 1'b0;
    o_load_fifo    = 1'b0;
    o_done         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          count_d = count_sat;
          index_d = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        o_clear_buffer = 1'b1;
        state_d        = StGuard;
      end
      StGuard: begin
        if (guard_q == GuardW'(GuardCycles - 1)) begin
          state_d = StWaitClr;
        end else begin
          guard_d = guard_q + GuardW'(1);
        end
      end
      StWaitClr: begin
        if (i_waiting) begin
          state_d = (count_q == '0) ? StFlush : StLoad;
        end
      end
      StLoad: begin
        // Full is sampled in the push cycle itself; coordinates hold while blocked.
        if (!i_fifo_full) begin
          o_load_fifo = 1'b1;
          index_d     = index_q + CntW'(1);
          if (index_d == count_q) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        // First cycle is a guard so the last push has time to show up as not-waiting.
        if (guard_q == '0) begin
          guard_d = GuardW'(1);
        end else begin
          guard_d = guard_q;
          if (i_waiting) begin
            o_done  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (i_abort) begin
      state_d        = StIdle;
      count_d        = count_q;
      index_d        = index_q;
      guard_d        = '0;
      o_clear_buffer = 1'b0;
      o_load_fifo    = 1'b0;
      o_done         = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      index_q <= '0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      guard_q <= guard_d;
    end
  end

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Self-checking bench for line_cmd_sequencer: a line-list model predicts every pushed segment,
// a monitor checks each cycle, directed scenarios pin timing and corner cases.
module tb_line_cmd_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_wr_en;
  logic [3:0]  i_wr_addr;
  logic [10:0] i_wr_x0, i_wr_x1;
  logic [10:0] i_wr_y0, i_wr_y1;
  logic [4:0]  i_line_count;
  logic        i_start, i_abort, i_waiting, i_fifo_full;
  logic        o_clear_buffer, o_load_fifo, o_busy, o_done;
  logic [10:0] o_x0, o_x1, o_y0, o_y1;

  always #5 i_clk = ~i_clk;

  line_cmd_sequencer dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_wr_en        (i_wr_en),
    .i_wr_addr      (i_wr_addr),
    .i_wr_x0        (i_wr_x0),
    .i_wr_x1        (i_wr_x1),
    .i_wr_y0        (i_wr_y0),
    .i_wr_y1        (i_wr_y1),
    .i_line_count   (i_line_count),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_waiting      (i_waiting),
    .i_fifo_full    (i_fifo_full),
    .o_clear_buffer (o_clear_buffer),
    .o_load_fifo    (o_load_fifo),
    .o_x0           (o_x0),
    .o_x1           (o_x1),
    .o_y0           (o_y0),
    .o_y1           (o_y1),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  typedef struct {
    int x0;
    int y0;
    int x1;
    int y1;
  } line_t;

  line_t mdl [16];
  line_t exp_q [$];
  line_t last_push;
  int    push_cyc_q [$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int clear_cnt = 0, done_cnt = 0, push_cnt = 0;
  int clear_cyc = 0, done_cyc = 0, start_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Per-cycle monitor against the line-list model.
  initial forever begin
    line_t e;
    @(negedge i_clk);
    if (i_reset_n) begin
      if (o_clear_buffer) begin
        clear_cnt++;
        clear_cyc = cyc;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_after_all_pushes", exp_q.size(), 0);
        check("done_with_waiting", int'(i_waiting), 1);
      end
      if (o_load_fifo) begin
        check("push_while_full", int'(i_fifo_full), 0);
        check("push_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("push_x0", int'(o_x0), e.x0);
          check("push_y0", int'(o_y0), e.y0);
          check("push_x1", int'(o_x1), e.x1);
          check("push_y1", int'(o_y1), e.y1);
        end
        last_push = '{int'(o_x0), int'(o_y0), int'(o_x1), int'(o_y1)};
        push_cyc_q.push_back(cyc);
        push_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int a, input int x0, input int y0, input int x1, input int y1);
    i_wr_en   = 1'b1;
    i_wr_addr = 4'(a);
    i_wr_x0   = 11'(x0);
    i_wr_y0   = 11'(y0);
    i_wr_x1   = 11'(x1);
    i_wr_y1   = 11'(y1);
    mdl[a]    = '{clamp(x0, 639), clamp(y0, 479), clamp(x1, 639), clamp(y1, 479)};
    tick();
    i_wr_en = 1'b0;
  endtask

  task automatic start_run(input int cnt);
    int n;
    n = (cnt > 16) ? 16 : cnt;
    for (int i = 0; i < n; i++) exp_q.push_back(mdl[i]);
    clear_cnt = 0;
    done_cnt  = 0;
    push_cnt  = 0;
    push_cyc_q.delete();
    i_line_count = 5'(cnt);
    i_start      = 1'b1;
    start_cyc    = cyc;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_pushes(input int n, input string name);
    for (int k = 0; k < 100 && push_cnt < n; k++) tick();
    check(name, int'(push_cnt >= n), 1);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 200 && done_cnt == 0; k++) tick();
    check(name, int'(done_cnt > 0), 1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_busy"}, int'(o_busy), 0);
    check({name, "_clear"}, int'(o_clear_buffer), 0);
    check({name, "_load"}, int'(o_load_fifo), 0);
    check({name, "_done"}, int'(o_done), 0);
    check({name, "_coords"}, int'({o_x0, o_y0, o_x1, o_y1} == '0), 1);
  endtask

  initial begin
    int rise_cyc;
    int drop_cyc;
    i_reset_n = 1'b0;
    i_wr_en = 1'b0; i_wr_addr = '0;
    i_wr_x0 = '0; i_wr_y0 = '0; i_wr_x1 = '0; i_wr_y1 = '0;
    i_line_count = '0; i_start = 1'b0; i_abort = 1'b0;
    i_waiting = 1'b1; i_fifo_full = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_outputs_zero("reset");
    i_reset_n = 1'b1;
    tick();

    // 1: three lines, done only once waiting returns after the last push.
    wr(0, 0, 0, 100, 100);
    wr(1, 10, 20, 30, 40);
    wr(2, 639, 479, 0, 0);
    start_run(3);
    wait_pushes(3, "t1_pushes_timeout");
    i_waiting = 1'b0;
    repeat (5) tick();
    check("t1_no_done_while_not_waiting", done_cnt, 0);
    i_waiting = 1'b1;
    rise_cyc  = cyc;
    wait_done("t1_done_timeout");
    check("t1_clear_count", clear_cnt, 1);
    check("t1_clear_latency", clear_cyc - start_cyc, 1);
    check("t1_push_count", push_cnt, 3);
    check("t1_first_push_latency", int'(push_cyc_q[0] - start_cyc >= 5), 1);
    check("t1_back_to_back", push_cyc_q[2] - push_cyc_q[0], 2);
    check("t1_done_count", done_cnt, 1);
    check("t1_done_timing", int'(done_cyc >= rise_cyc && done_cyc <= rise_cyc + 1), 1);
    check("t1_last_x0", last_push.x0, 639);
    check("t1_last_y0", last_push.y0, 479);
    tick();
    check("t1_idle_after_done", int'(o_busy), 0);

    // 2: out-of-range coordinates clamp to the screen edge.
    wr(0, 1000, 600, 700, 500);
    start_run(1);
    wait_done("t2_done_timeout");
    check("t2_x0_clamped", last_push.x0, 639);
    check("t2_y0_clamped", last_push.y0, 479);
    check("t2_x1_clamped", last_push.x1, 639);
    check("t2_y1_clamped", last_push.y1, 479);

    // 3: back-pressure for 10 cycles after the second push.
    wr(0, 5, 6, 7, 8);
    wr(3, 1, 2, 3, 4);
    start_run(4);
    wait_pushes(2, "t3_two_pushes_timeout");
    i_fifo_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      check("t3_hold_no_push", int'(o_load_fifo), 0);
      check("t3_hold_x0", int'(o_x0), 639);
      check("t3_hold_y0", int'(o_y0), 479);
    end
    @(posedge i_clk);
    #1;
    i_fifo_full = 1'b0;
    drop_cyc    = cyc;
    wait_pushes(3, "t3_resume_timeout");
    check("t3_resume_cycle", push_cyc_q[2], drop_cyc);
    wait_done("t3_done_timeout");
    check("t3_push_count", push_cnt, 4);
    check("t3_last_x0", last_push.x0, 1);

    // 4: zero lines: clear, wait for idle, done, never a push.
    i_waiting = 1'b0;
    start_run(0);
    repeat (8) tick();
    check("t4_clear_count", clear_cnt, 1);
    check("t4_no_early_done", done_cnt, 0);
    check("t4_busy_waiting", int'(o_busy), 1);
    i_waiting = 1'b1;
    wait_done("t4_done_timeout");
    check("t4_push_count", push_cnt, 0);

    // 5: abort after one push, then a fresh run replays from entry 0.
    start_run(3);
    wait_pushes(1, "t5_first_push_timeout");
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("t5_idle_after_abort", int'(o_busy), 0);
    repeat (10) tick();
    check("t5_push_count", push_cnt, 1);
    check("t5_no_done", done_cnt, 0);
    exp_q.delete();
    start_run(2);
    wait_done("t5_replay_done_timeout");
    check("t5_replay_pushes", push_cnt, 2);
    check("t5_replay_last_x0", last_push.x0, 10);

    // 6: busy write/start are ignored; reset mid-flush clears outputs at once.
    start_run(2);
    wait_pushes(2, "t6_pushes_timeout");
    i_waiting = 1'b0;
    tick();
    i_wr_en = 1'b1; i_wr_addr = 4'd0;
    i_wr_x0 = 11'd9; i_wr_y0 = 11'd9; i_wr_x1 = 11'd9; i_wr_y1 = 11'd9;
    tick();
    i_wr_en = 1'b0;
    i_start = 1'b1; i_line_count = 5'd5;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    check("t6_busy_start_no_clear", clear_cnt, 1);
    check("t6_busy_start_no_push", push_cnt, 2);
    check("t6_still_busy", int'(o_busy), 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_async_reset");
    tick();
    tick();
    i_reset_n = 1'b1;
    check("t6_no_done_on_reset", done_cnt, 0);
    i_waiting = 1'b1;
    start_run(1);
    wait_done("t6_after_reset_timeout");
    check("t6_list_unchanged_x0", last_push.x0, 5);
    check("t6_list_unchanged_y1", last_push.y1, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
